// File: rtl/cv32e40p_apu_master_disp_pkg.sv
// Shared widths and payload types for the core-side APU dispatcher and its tag FIFO.
// Request payload travels issue -> hold register -> APU port; response goes APU -> writeback.
package cv32e40p_apu_disp_pkg;

  localparam int NARGS    = 3;
  localparam int WOP      = 6;
  localparam int NDSFLAGS = 15;
  localparam int NUSFLAGS = 5;
  localparam int DEPTH    = 4;
  localparam int ADDR_W   = 6;
  localparam int CNT_W    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [NARGS*32-1:0] operands;
    logic [WOP-1:0]      op;
    logic [NDSFLAGS-1:0] flags;
    logic [ADDR_W-1:0]   waddr;
  } apu_req_t;

  typedef struct packed {
    logic [31:0]         data;
    logic [NUSFLAGS-1:0] flags;
  } apu_rsp_t;

  // One slot per granted op plus the hold register must fit in the result tracking.
  function automatic logic reserve_block(input logic [CNT_W-1:0] cnt, input logic hold);
    return (32'(cnt) + 32'(hold)) >= 32'(DEPTH);
  endfunction

endpackage

// File: rtl/cv32e40p_apu_master_disp_if.sv
// APU master/responder bundle: request/grant handshake, flush, and unthrottled result return.
// The master drives request payload and flush; the responder drives grant and results.
interface cv32e40p_apu_master_disp_if;
  import cv32e40p_apu_disp_pkg::*;

  logic                req;
  logic                gnt;
  logic [NARGS*32-1:0] operands;
  logic [WOP-1:0]      op;
  logic [NDSFLAGS-1:0] flags;
  logic                flush;
  logic                rvalid;
  logic [31:0]         rdata;
  logic [NUSFLAGS-1:0] rflags;

  modport master (
    output req, operands, op, flags, flush,
    input  gnt, rvalid, rdata, rflags
  );

  modport slave (
    input  req, operands, op, flags, flush,
    output gnt, rvalid, rdata, rflags
  );

endinterface

// File: rtl/cv32e40p_apu_master_disp_tag_fifo.sv
// In-order tag FIFO of destination addresses; push/pop take effect at the clock edge, head is combinational.
// Push while full is dropped unless a pop happens in the same cycle; flush and reset empty it.
module cv32e40p_apu_tag_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 6,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/cv32e40p_apu_master_disp.sv
// Core-side APU initiator: accept->req 1 cycle, rvalid->writeback 1 cycle, one op per cycle when granted.
// Issue stalls while the hold register is ungranted or result slots are all reserved; results are never stalled.
module cv32e40p_apu_master_disp
  import cv32e40p_apu_disp_pkg::*;
(
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        flush_i,
  input  logic                        issue_valid_i,
  output logic                        issue_ready_o,
  input  logic [NARGS*32-1:0]         issue_operands_i,
  input  logic [WOP-1:0]              issue_op_i,
  input  logic [NDSFLAGS-1:0]         issue_flags_i,
  input  logic [ADDR_W-1:0]           issue_waddr_i,
  cv32e40p_apu_master_disp_if.master  apu,
  output logic                        wb_valid_o,
  output logic [ADDR_W-1:0]           wb_waddr_o,
  output logic [31:0]                 wb_data_o,
  output logic [NUSFLAGS-1:0]         wb_flags_o,
  output logic                        busy_o,
  output logic                        proto_err_o
);

  apu_req_t          hold_q;
  logic              hold_valid;
  apu_rsp_t          wb_rsp_q;
  logic [ADDR_W-1:0] wb_waddr_q;
  logic              wb_valid_q;
  logic              proto_err_q;

  logic              fire;
  logic              accept;
  logic              push;
  logic              pop;
  logic              stray;
  logic [ADDR_W-1:0] tag_head;
  logic [CNT_W-1:0]  tag_count;
  logic              tag_full;
  logic              tag_empty;

  assign fire          = hold_valid & apu.gnt;
  assign issue_ready_o = ~flush_i & (~hold_valid | fire) & ~reserve_block(tag_count, hold_valid);
  assign accept        = issue_valid_i & issue_ready_o;

  // Anything observed during a flush belongs to the killed stream.
  assign push  = fire & ~flush_i & (~tag_full | pop);
  assign pop   = apu.rvalid & ~tag_empty & ~flush_i;
  assign stray = apu.rvalid & tag_empty & ~flush_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hold_valid <= 1'b0;
      hold_q     <= '0;
    end else if (flush_i) begin
      hold_valid <= 1'b0;
    end else if (accept) begin
      hold_valid      <= 1'b1;
      hold_q.operands <= issue_operands_i;
      hold_q.op       <= issue_op_i;
      hold_q.flags    <= issue_flags_i;
      hold_q.waddr    <= issue_waddr_i;
    end else if (fire) begin
      hold_valid <= 1'b0;
    end
  end

  cv32e40p_apu_tag_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_W)
  ) u_tag_fifo (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .flush    (flush_i),
    .push     (push),
    .push_dat (hold_q.waddr),
    .pop      (pop),
    .head     (tag_head),
    .count    (tag_count),
    .full     (tag_full),
    .empty    (tag_empty)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wb_valid_q  <= 1'b0;
      wb_waddr_q  <= '0;
      wb_rsp_q    <= '0;
      proto_err_q <= 1'b0;
    end else begin
      wb_valid_q <= pop;
      if (pop) begin
        wb_waddr_q     <= tag_head;
        wb_rsp_q.data  <= apu.rdata;
        wb_rsp_q.flags <= apu.rflags;
      end
      if (stray) begin
        proto_err_q <= 1'b1;
      end
    end
  end

  assign apu.req      = hold_valid;
  assign apu.operands = hold_q.operands;
  assign apu.op       = hold_q.op;
  assign apu.flags    = hold_q.flags;
  assign apu.flush    = flush_i;

  assign wb_valid_o  = wb_valid_q;
  assign wb_waddr_o  = wb_waddr_q;
  assign wb_data_o   = wb_rsp_q.data;
  assign wb_flags_o  = wb_rsp_q.flags;
  assign busy_o      = hold_valid | ~tag_empty;
  assign proto_err_o = proto_err_q;

endmodule
